// File: rtl/mux_reduce_pipe.sv
// rtl/mux_reduce_pipe.sv - pipelined mux-cell tree for channel select and OR/AND/XOR reduction
module mux_reduce_pipe #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int LVL  = $clog2(N_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [1:0]          mode,
    input  logic [LVL-1:0]      sel,
    input  logic [N_CH*W-1:0]   in_data,
    output logic                out_valid,
    output logic [W-1:0]        out_data
);

    // Bitwise 2:1 mux cell: every bit picks d1 when its select bit is set.
    function automatic logic [W-1:0] bmux(
        input logic [W-1:0] s,
        input logic [W-1:0] d1,
        input logic [W-1:0] d0
    );
        logic [W-1:0] y;
        for (int b = 0; b < W; b++) begin
            y[b] = s[b] ? d1[b] : d0[b];
        end
        return y;
    endfunction

    // One tree node. Each mode's result comes from a single mux cell keyed by
    // the right operand (or the sel bit), and the mode itself steers a small
    // mux tree so the node never needs a logic operator beyond inversion.
    function automatic logic [W-1:0] node_fn(
        input logic [1:0]   m,
        input logic         s,
        input logic [W-1:0] left,
        input logic [W-1:0] right
    );
        logic [W-1:0] sel_y;
        logic [W-1:0] or_y;
        logic [W-1:0] and_y;
        logic [W-1:0] xor_y;
        logic [W-1:0] lo_y;
        logic [W-1:0] hi_y;
        sel_y = bmux({W{s}}, right, left);
        or_y  = bmux(right, {W{1'b1}}, left);
        and_y = bmux(right, left, {W{1'b0}});
        xor_y = bmux(right, ~left, left);
        lo_y  = bmux({W{m[0]}}, or_y, sel_y);
        hi_y  = bmux({W{m[0]}}, xor_y, and_y);
        return bmux({W{m[1]}}, hi_y, lo_y);
    endfunction

    genvar k;
    genvar i;
    for (k = 0; k < LVL; k++) begin : g_lvl
        // NI nodes enter this level, NO leave it; SW sel bits are still unconsumed
        // and bit 0 of them steers this level.
        localparam int NI = N_CH >> k;
        localparam int NO = NI / 2;
        localparam int SW = LVL - k;

        logic [NI*W-1:0] din;
        logic [1:0]      mode_i;
        logic [SW-1:0]   sel_i;
        logic            vld_i;
        logic [NO*W-1:0] node_d;
        logic [NO*W-1:0] node_q;
        logic            vld_q;

        if (k == 0) begin : g_src
            assign din    = in_data;
            assign mode_i = mode;
            assign sel_i  = sel;
            assign vld_i  = in_valid;
        end else begin : g_chain
            assign din    = g_lvl[k-1].node_q;
            assign mode_i = g_lvl[k-1].g_fwd.mode_q;
            assign sel_i  = g_lvl[k-1].g_fwd.sel_q;
            assign vld_i  = g_lvl[k-1].vld_q;
        end

        for (i = 0; i < NO; i++) begin : g_node
            assign node_d[i*W +: W] = node_fn(mode_i, sel_i[0],
                                              din[(2*i)*W +: W],
                                              din[(2*i+1)*W +: W]);
        end

        // Stage register: valid always follows upstream, data only loads on valid
        // so the last result is held through bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                node_q <= '0;
            end else begin
                vld_q <= vld_i;
                if (vld_i) begin
                    node_q <= node_d;
                end
            end
        end

        // Mode and remaining sel bits ride along with the transaction; the root
        // stage has no downstream consumer for them, so they stop here.
        if (k < LVL - 1) begin : g_fwd
            logic [1:0]    mode_q;
            logic [SW-2:0] sel_q;

            // Side-band register, loads together with the node data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    mode_q <= 2'b00;
                    sel_q  <= '0;
                end else if (vld_i) begin
                    mode_q <= mode_i;
                    sel_q  <= sel_i[SW-1:1];
                end
            end
        end
    end

    assign out_valid = g_lvl[LVL-1].vld_q;
    assign out_data  = g_lvl[LVL-1].node_q;

endmodule

// File: tb/tb_mux_reduce_pipe.sv
// tb/tb_mux_reduce_pipe.sv - self-checking bench for mux_reduce_pipe over three configurations
module tb_mux_reduce_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic         v4, ov4;
    logic [1:0]   m4, s4;
    logic [31:0]  d4;
    logic [7:0]   od4;

    logic         v2, ov2;
    logic [1:0]   m2;
    logic [0:0]   s2;
    logic [15:0]  d2;
    logic [7:0]   od2;

    logic         v8, ov8;
    logic [1:0]   m8;
    logic [2:0]   s8;
    logic [127:0] d8;
    logic [15:0]  od8;

    always #5 clk = ~clk;

    mux_reduce_pipe #(.N_CH(4), .W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .mode(m4), .sel(s4),
        .in_data(d4), .out_valid(ov4), .out_data(od4));

    mux_reduce_pipe #(.N_CH(2), .W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .mode(m2), .sel(s2),
        .in_data(d2), .out_valid(ov2), .out_data(od2));

    mux_reduce_pipe #(.N_CH(8), .W(16)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .mode(m8), .sel(s8),
        .in_data(d8), .out_valid(ov8), .out_data(od8));

    // Reference: pick channel sel, or fold all channels with |, &, ^.
    function automatic logic [15:0] ref_model(input int n, input int w, input logic [1:0] m,
                                              input int s, input logic [127:0] d);
        logic [15:0] mask;
        logic [15:0] ch;
        logic [15:0] acc;
        mask = 16'((32'd1 << w) - 1);
        acc  = (m == 2'd2) ? mask : 16'h0;
        for (int c = 0; c < n; c++) begin
            ch = 16'(d >> (c * w)) & mask;
            case (m)
                2'd0: if (c == s) acc = ch;
                2'd1: acc = acc | ch;
                2'd2: acc = acc & ch;
                default: acc = acc ^ ch;
            endcase
        end
        return acc;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle4;
        v4 = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset;
        rst = 1'b1; v4 = 1'b1; m4 = 2'd0; s4 = 2'd2; d4 = 32'h44332211;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                rst = 1'b0; v4 = 1'b0;
            end
            step();
            n_checks++;
            if (ov4 !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid cycle %0d: got %b want 0", c, ov4);
            end
            n_checks++;
            if (od4 !== 8'h00) begin
                n_fail++; $display("FAIL reset_data cycle %0d: got %h want 00", c, od4);
            end
        end
        n_checks++;
        if (ov2 !== 1'b0 || od2 !== 8'h00 || ov8 !== 1'b0 || od8 !== 16'h0) begin
            n_fail++; $display("FAIL reset_sweep: got %b/%h %b/%h want 0/0", ov2, od2, ov8, od8);
        end
    endtask

    task automatic test_select;
        logic [1:0] sels [4];
        logic [7:0] exp  [4];
        sels = '{2'd2, 2'd0, 2'd1, 2'd3};
        exp  = '{8'h33, 8'h11, 8'h22, 8'h44};
        d4 = 32'h44332211; m4 = 2'd0;
        for (int s = 0; s < 6; s++) begin
            if (s < 4) begin
                v4 = 1'b1; s4 = sels[s];
            end else begin
                v4 = 1'b0; s4 = 2'(s);
            end
            step();
            if (s >= 1 && s <= 4) begin
                n_checks++;
                if (ov4 !== 1'b1 || od4 !== exp[s-1]) begin
                    n_fail++; $display("FAIL select %0d: got %b/%h want 1/%h", s-1, ov4, od4, exp[s-1]);
                end
            end else if (s == 5) begin
                n_checks++;
                if (ov4 !== 1'b0 || od4 !== 8'h44) begin
                    n_fail++; $display("FAIL select_hold: got %b/%h want 0/44", ov4, od4);
                end
            end
        end
        idle4();
    endtask

    task automatic test_back_to_back;
        logic [1:0]  modes [3];
        logic [31:0] datas [3];
        logic [7:0]  exp   [3];
        modes = '{2'd1, 2'd2, 2'd3};
        datas = '{32'h80040201, 32'h33FF3CF0, 32'h55AAF00F};
        exp   = '{8'h87, 8'h30, 8'h00};
        for (int s = 0; s < 4; s++) begin
            if (s < 3) begin
                v4 = 1'b1; m4 = modes[s]; d4 = datas[s]; s4 = 2'd3;
            end else begin
                v4 = 1'b0; m4 = 2'd0; d4 = 32'hFFFFFFFF;
            end
            step();
            if (s >= 1) begin
                n_checks++;
                if (ov4 !== 1'b1 || od4 !== exp[s-1]) begin
                    n_fail++; $display("FAIL reduce %0d: got %b/%h want 1/%h", s-1, ov4, od4, exp[s-1]);
                end
            end
        end
        idle4();
    endtask

    task automatic test_bubbles;
        logic       pat [4];
        logic [7:0] exp [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp = '{8'h22, 8'h22, 8'h22, 8'h0F};
        for (int s = 0; s < 5; s++) begin
            v4 = (s < 4) ? pat[s] : 1'b0;
            if (s == 0) begin
                m4 = 2'd0; s4 = 2'd1; d4 = 32'h44332211;
            end else begin
                m4 = 2'd3; s4 = 2'd0; d4 = 32'h01020408;
            end
            step();
            if (s >= 1) begin
                n_checks++;
                if (ov4 !== pat[s-1] || od4 !== exp[s-1]) begin
                    n_fail++; $display("FAIL bubble %0d: got %b/%h want %b/%h", s-1, ov4, od4, pat[s-1], exp[s-1]);
                end
            end
        end
        idle4();
    endtask

    task automatic test_midflight_reset;
        v4 = 1'b1; m4 = 2'd0; s4 = 2'd0; d4 = 32'hAABBCCDD;
        step();
        v4 = 1'b1; m4 = 2'd1; d4 = 32'h11111111; rst = 1'b1;
        step();
        n_checks++;
        if (ov4 !== 1'b0 || od4 !== 8'h00) begin
            n_fail++; $display("FAIL midrst_edge: got %b/%h want 0/00", ov4, od4);
        end
        rst = 1'b0; v4 = 1'b1; m4 = 2'd1; d4 = 32'h00000081;
        step();
        n_checks++;
        if (ov4 !== 1'b0 || od4 !== 8'h00) begin
            n_fail++; $display("FAIL midrst_flush: got %b/%h want 0/00", ov4, od4);
        end
        v4 = 1'b0;
        step();
        n_checks++;
        if (ov4 !== 1'b1 || od4 !== 8'h81) begin
            n_fail++; $display("FAIL midrst_new: got %b/%h want 1/81", ov4, od4);
        end
        step();
        n_checks++;
        if (ov4 !== 1'b0 || od4 !== 8'h81) begin
            n_fail++; $display("FAIL midrst_after: got %b/%h want 0/81", ov4, od4);
        end
        idle4();
    endtask

    // cfg 0: N_CH=4/W=8, 1: N_CH=2/W=8, 2: N_CH=8/W=16
    task automatic test_random(input int cfg, input int ntx);
        logic         tv [64];
        logic [1:0]   tm [64];
        int           ts [64];
        logic [127:0] td [64];
        logic [15:0]  te [64];
        logic [15:0]  last;
        logic [15:0]  got_d;
        logic         got_v;
        int n, w, lvl, j;
        n   = (cfg == 0) ? 4 : (cfg == 1) ? 2 : 8;
        w   = (cfg == 2) ? 16 : 8;
        lvl = $clog2(n);
        last = 16'h0;
        for (int t = 0; t < ntx; t++) begin
            tv[t] = (t == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tm[t] = 2'($urandom_range(0, 3));
            ts[t] = $urandom_range(0, n - 1);
            td[t] = {$urandom, $urandom, $urandom, $urandom};
            te[t] = ref_model(n, w, tm[t], ts[t], td[t]);
        end
        for (int s = 0; s < ntx + lvl; s++) begin
            case (cfg)
                0: begin
                    v4 = (s < ntx) ? tv[s] : 1'b0;
                    if (s < ntx) begin m4 = tm[s]; s4 = 2'(ts[s]); d4 = td[s][31:0]; end
                end
                1: begin
                    v2 = (s < ntx) ? tv[s] : 1'b0;
                    if (s < ntx) begin m2 = tm[s]; s2 = 1'(ts[s]); d2 = td[s][15:0]; end
                end
                default: begin
                    v8 = (s < ntx) ? tv[s] : 1'b0;
                    if (s < ntx) begin m8 = tm[s]; s8 = 3'(ts[s]); d8 = td[s]; end
                end
            endcase
            step();
            j = s - lvl + 1;
            if (j >= 0 && j < ntx) begin
                if (tv[j]) last = te[j];
                case (cfg)
                    0: begin got_v = ov4; got_d = {8'h00, od4}; end
                    1: begin got_v = ov2; got_d = {8'h00, od2}; end
                    default: begin got_v = ov8; got_d = od8; end
                endcase
                n_checks++;
                if (got_v !== tv[j]) begin
                    n_fail++; $display("FAIL rand_valid cfg%0d tx%0d: got %b want %b", cfg, j, got_v, tv[j]);
                end
                n_checks++;
                if (got_d !== last) begin
                    n_fail++; $display("FAIL rand_data cfg%0d tx%0d: got %h want %h", cfg, j, got_d, last);
                end
            end
        end
        v4 = 1'b0; v2 = 1'b0; v8 = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        v4 = 1'b0; m4 = 2'd0; s4 = 2'd0; d4 = '0;
        v2 = 1'b0; m2 = 2'd0; s2 = 1'b0; d2 = '0;
        v8 = 1'b0; m8 = 2'd0; s8 = 3'd0; d8 = '0;
        test_reset();
        test_select();
        test_back_to_back();
        test_bubbles();
        test_midflight_reset();
        test_random(0, 60);
        test_random(1, 60);
        test_random(2, 60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
